// File: rtl/param_sram_bank_if.sv
// param_sram_bank_if: host single-port bus plus burst stream for param_sram_bank
interface param_sram_bank_if #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 64,
    parameter int ADDR_W = $clog2(DEPTH),
    parameter int LEN_W  = ADDR_W + 1
);
    logic                cs;
    logic                oe;
    logic                web;
    logic [DATA_W/8-1:0] bweb;
    logic [ADDR_W-1:0]   addr;
    logic [DATA_W-1:0]   wdata;
    logic [DATA_W-1:0]   rdata;
    logic                busy;
    logic                burst_start;
    logic [ADDR_W-1:0]   burst_base;
    logic [LEN_W-1:0]    burst_len;
    logic                burst_valid;
    logic                burst_ready;
    logic [DATA_W-1:0]   burst_data;
    logic                burst_last;
    logic                burst_done;
    modport master (
        output cs, oe, web, bweb, addr, wdata, burst_start, burst_base, burst_len, burst_ready,
        input  rdata, busy, burst_valid, burst_data, burst_last, burst_done
    );
    modport slave (
        input  cs, oe, web, bweb, addr, wdata, burst_start, burst_base, burst_len, burst_ready,
        output rdata, busy, burst_valid, burst_data, burst_last, burst_done
    );
endinterface

// File: rtl/param_sram_bank.sv
// param_sram_bank: byte-masked parameter SRAM with registered host port and burst-read stream.
// Define PARAM_SRAM_INIT_EN to zero-fill the array after every reset (busy for DEPTH cycles).
module param_sram_bank #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 64,
    parameter int ADDR_W = $clog2(DEPTH),
    parameter int LEN_W  = ADDR_W + 1
) (
    input logic             clk,
    input logic             rst_n,
    param_sram_bank_if.slave bus
);
    localparam int NB = DATA_W / 8;
    typedef enum logic [1:0] {S_INIT, S_IDLE, S_BURST} state_t;
`ifdef PARAM_SRAM_INIT_EN
    localparam state_t RST_STATE = S_INIT;
`else
    localparam state_t RST_STATE = S_IDLE;
`endif
    state_t            r_state;
    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_rdata, r_data, w_merged;
    logic [ADDR_W-1:0] r_ptr;
    logic [LEN_W-1:0]  r_rem;
    logic              r_valid, r_last, r_done;
    logic              w_host, w_issue;

    assign w_host  = rst_n && r_state == S_IDLE && bus.cs;
    assign w_issue = r_state == S_BURST && r_rem != '0 && (!r_valid || bus.burst_ready);

    always_comb begin
        w_merged = r_mem[bus.addr];
        for (int b = 0; b < NB; b++)
            if (!bus.bweb[b]) w_merged[8*b +: 8] = bus.wdata[8*b +: 8];
    end

    always_ff @(posedge clk) begin
        if (r_state == S_INIT) r_mem[r_ptr] <= '0;
        else if (w_host && !bus.web) r_mem[bus.addr] <= w_merged;
    end

    // r_ptr is the zero-fill pointer in INIT and the wrapping read address in BURST
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= RST_STATE;
            r_rdata <= '0;
            r_data  <= '0;
            r_valid <= 1'b0;
            r_last  <= 1'b0;
            r_done  <= 1'b0;
            r_ptr   <= '0;
            r_rem   <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_INIT: begin
                    r_ptr <= r_ptr + ADDR_W'(1);
                    if (r_ptr == ADDR_W'(DEPTH - 1)) r_state <= S_IDLE;
                end
                S_IDLE: begin
                    if (bus.cs) r_rdata <= bus.web ? r_mem[bus.addr] : w_merged;
                    if (bus.burst_start) begin
                        r_ptr <= bus.burst_base;
                        r_rem <= bus.burst_len;
                        if (bus.burst_len == '0) r_done <= 1'b1;
                        else r_state <= S_BURST;
                    end
                end
                S_BURST: begin
                    if (w_issue) begin
                        r_data  <= r_mem[r_ptr];
                        r_valid <= 1'b1;
                        r_last  <= r_rem == LEN_W'(1);
                        r_ptr   <= r_ptr + ADDR_W'(1);
                        r_rem   <= r_rem - LEN_W'(1);
                    end else if (r_valid && bus.burst_ready) begin
                        r_valid <= 1'b0;
                        r_last  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.rdata       = bus.oe ? r_rdata : '0;
    assign bus.busy        = r_state != S_IDLE;
    assign bus.burst_valid = r_valid;
    assign bus.burst_data  = r_data;
    assign bus.burst_last  = r_last;
    assign bus.burst_done  = r_done;
endmodule

// File: tb/tb_param_sram_bank.sv
// tb_param_sram_bank: directed bench with a word-level memory model and a stream scoreboard.
module tb_param_sram_bank;
    localparam int DEPTH = 64;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    param_sram_bank_if bus ();
    param_sram_bank dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    typedef struct {
        logic [31:0] d;
        logic        l;
    } exp_t;

    int          n_vec = 0;
    int          n_err = 0;
    exp_t        exp_q[$];
    logic [31:0] m_mem[DEPTH];
    logic [31:0] got[$];
    logic        prev_stall = 1'b0;
    logic [31:0] prev_data = '0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // every accepted stream word must be the next model word; stalled words must not move
    always @(negedge clk) begin
        if (!rst_n) prev_stall = 1'b0;
        else begin
            if (prev_stall) begin
                chk("hold_valid", 32'(bus.burst_valid), 1);
                chk("hold_data", bus.burst_data, prev_data);
            end
            if (bus.burst_valid && bus.burst_ready) begin
                chk("exp_avail", 32'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0) begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("stream_data", bus.burst_data, e.d);
                    chk("stream_last", 32'(bus.burst_last), 32'(e.l));
                end
            end
            prev_stall = bus.burst_valid && !bus.burst_ready;
            prev_data  = bus.burst_data;
        end
    end

    task automatic hwrite(input logic [5:0] a, input logic [31:0] d, input logic [3:0] m);
        bus.cs = 1'b1; bus.web = 1'b0; bus.addr = a; bus.wdata = d; bus.bweb = m;
        tick;
        bus.cs = 1'b0; bus.web = 1'b1;
        for (int b = 0; b < 4; b++)
            if (!m[b]) m_mem[a][8*b +: 8] = d[8*b +: 8];
    endtask

    task automatic hread(input logic [5:0] a);
        bus.cs = 1'b1; bus.web = 1'b1; bus.addr = a;
        tick;
        bus.cs = 1'b0;
    endtask

    task automatic burst(input logic [5:0] base, input logic [6:0] len, input logic bp,
                         input logic poke, output int cyc);
        logic [3:0] pat;
        pat = 4'b1001;
        for (int i = 0; i < int'(len); i++) begin
            exp_t e;
            e.d = m_mem[6'(int'(base) + i)];
            e.l = (i == int'(len) - 1);
            exp_q.push_back(e);
        end
        got.delete();
        bus.burst_base = base; bus.burst_len = len; bus.burst_ready = 1'b1; bus.burst_start = 1'b1;
        tick;
        bus.burst_start = 1'b0;
        chk("busy_in_burst", 32'(bus.busy), 1);
        cyc = 0;
        do begin
            bus.burst_ready = bp ? pat[cyc % 4] : 1'b1;
            bus.cs = poke; bus.web = 1'b0; bus.addr = base; bus.wdata = '1; bus.bweb = '0;
            if (bus.burst_valid && bus.burst_ready) got.push_back(bus.burst_data);
            tick;
            cyc++;
        end while (!bus.burst_done && cyc < 100);
        bus.cs = 1'b0; bus.web = 1'b1; bus.burst_ready = 1'b0;
        chk("done_seen", 32'(bus.burst_done), 1);
        chk("busy_after_done", 32'(bus.busy), 0);
        chk("queue_drained", 32'(exp_q.size()), 0);
        chk("word_count", 32'(got.size()), 32'(len));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int          n, cyc;
        logic [31:0] wrap_exp[4];
        wrap_exp = '{32'd62, 32'd63, 32'd0, 32'd1};
        bus.cs = 1'b0; bus.oe = 1'b1; bus.web = 1'b1; bus.bweb = '1; bus.addr = '0; bus.wdata = '0;
        bus.burst_start = 1'b0; bus.burst_base = '0; bus.burst_len = '0; bus.burst_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_rdata", bus.rdata, 0);
        chk("rst_valid", 32'(bus.burst_valid), 0);
        chk("rst_last", 32'(bus.burst_last), 0);
        chk("rst_done", 32'(bus.burst_done), 0);
        chk("rst_data", bus.burst_data, 0);
        rst_n = 1'b1;
`ifdef PARAM_SRAM_INIT_EN
        chk("init_busy", 32'(bus.busy), 1);
        n = 0;
        while (bus.busy && n < 200) begin tick; n++; end
        chk("init_cycles", n, 64);
        for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
        hread(63);
        chk("init_rd63", bus.rdata, 32'h0);
`else
        chk("busy_after_rst", 32'(bus.busy), 0);
`endif
        hwrite(5, 32'hAABBCCDD, 4'b0000);
        chk("wt_full", bus.rdata, 32'hAABBCCDD);
        hwrite(5, 32'h11223344, 4'b1010);
        chk("wt_mask", bus.rdata, m_mem[5]);
        hread(5);
        chk("mask_lit", bus.rdata, 32'hAA22CC44);
        chk("mask_model", bus.rdata, m_mem[5]);
        bus.oe = 1'b0;
        #1;
        chk("oe_low", bus.rdata, 0);
        bus.oe = 1'b1;
        tick;
        chk("cs0_hold", bus.rdata, 32'hAA22CC44);

        for (int i = 0; i < DEPTH; i++) hwrite(6'(i), 32'(i), 4'b0000);
        hread(7);
        chk("preload_rd7", bus.rdata, 32'd7);

        burst(10, 4, 1'b0, 1'b0, cyc);
        chk("fr_cycles", cyc, 5);
        for (int i = 0; i < got.size(); i++) chk("fr_word", got[i], 32'(10 + i));
        tick;
        chk("done_pulse_once", 32'(bus.burst_done), 0);

        burst(10, 4, 1'b1, 1'b0, cyc);
        chk("bp_cycles", cyc, 9);
        for (int i = 0; i < got.size(); i++) chk("bp_word", got[i], 32'(10 + i));

        burst(62, 4, 1'b0, 1'b0, cyc);
        for (int i = 0; i < got.size() && i < 4; i++) chk("wrap_word", got[i], wrap_exp[i]);

        bus.burst_base = 6'd3; bus.burst_len = '0; bus.burst_start = 1'b1;
        tick;
        bus.burst_start = 1'b0;
        chk("len0_done", 32'(bus.burst_done), 1);
        chk("len0_valid", 32'(bus.burst_valid), 0);
        chk("len0_busy", 32'(bus.busy), 0);
        tick;
        chk("len0_done_clear", 32'(bus.burst_done), 0);
        chk("len0_no_valid", 32'(bus.burst_valid), 0);

        hread(9);
        burst(20, 4, 1'b0, 1'b1, cyc);
        chk("poke_latch_hold", bus.rdata, 32'd9);
        hread(20);
        chk("poke_mem_lit", bus.rdata, 32'd20);
        chk("poke_mem_model", bus.rdata, m_mem[20]);

        for (int i = 0; i < 8; i++) begin
            exp_t e;
            e.d = m_mem[i];
            e.l = (i == 7);
            exp_q.push_back(e);
        end
        bus.burst_base = '0; bus.burst_len = 7'd8; bus.burst_ready = 1'b1; bus.burst_start = 1'b1;
        tick;
        bus.burst_start = 1'b0;
        repeat (3) tick;
        chk("mid_valid_pre", 32'(bus.burst_valid), 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(bus.burst_valid), 0);
        chk("mid_rst_done", 32'(bus.burst_done), 0);
        chk("mid_rst_last", 32'(bus.burst_last), 0);
        chk("mid_rst_data", bus.burst_data, 0);
        exp_q.delete();
        bus.burst_ready = 1'b0;
        tick;
        rst_n = 1'b1;
`ifdef PARAM_SRAM_INIT_EN
        n = 0;
        while (bus.busy && n < 200) begin tick; n++; end
        chk("reinit_cycles", n, 64);
`else
        chk("mid_rst_busy", 32'(bus.busy), 0);
`endif
        tick;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
